// File: rtl/fp32_sub_seq.sv
// fp32_sub_seq: multi-cycle FP32 subtractor, result = a - b.
// Truncating datapath: the implicit leading 1 is always applied, there is
// no rounding, and zero/denormal/Inf/NaN inputs get no special handling.
// Operation flow: IDLE -> ALIGN -> ADDSUB -> NORM (one shift per edge) -> DONE.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; aborts any operation in flight
//   in_valid   a/b valid        in_ready   high only in IDLE
//   a, b       FP32 minuend / subtrahend
//   out_valid  result valid, held until consumed
//   out_ready  consumer accepts result
//   result     registered FP32 difference
//   busy       high in any state other than IDLE
//
// Handshake: operands transfer on a rising edge where in_valid & in_ready;
// the result transfers on a rising edge where out_valid & out_ready. Once
// raised, out_valid and result hold until that transfer happens.
module fp32_sub_seq #(
    parameter int NORM_LIMIT = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADDSUB,
        S_NORM,
        S_DONE
    } state_t;

    localparam logic [4:0] LIMIT = 5'(NORM_LIMIT);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;          // sign bit stored already inverted
    logic [23:0] ma_q, ma_d;
    logic [23:0] mb_q, mb_d;
    logic [7:0]  er_q, er_d;
    logic [24:0] sum_q, sum_d;
    logic        sign_q, sign_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        out_valid_q, out_valid_d;

    // Scratch values for the ALIGN and NORM steps
    logic [7:0]  diff;
    logic [23:0] full_ma, full_mb;
    logic [24:0] sum_n;
    logic [7:0]  er_n;
    logic        finish;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        er_d        = er_q;
        sum_d       = sum_q;
        sign_d      = sign_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        diff        = 8'd0;
        full_ma     = {1'b1, a_q[22:0]};
        full_mb     = {1'b1, b_q[22:0]};
        sum_n       = sum_q;
        er_n        = er_q;
        finish      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = {~b[31], b[30:0]};
                    state_d = S_ALIGN;
                end
            end

            S_ALIGN: begin
                // Shift the smaller-exponent mantissa right; 24+ flushes to 0
                if (a_q[30:23] > b_q[30:23]) begin
                    diff = a_q[30:23] - b_q[30:23];
                    ma_d = full_ma;
                    mb_d = (diff >= 8'd24) ? 24'd0 : (full_mb >> diff);
                    er_d = a_q[30:23];
                end else begin
                    diff = b_q[30:23] - a_q[30:23];
                    ma_d = (diff >= 8'd24) ? 24'd0 : (full_ma >> diff);
                    mb_d = full_mb;
                    er_d = b_q[30:23];
                end
                state_d = S_ADDSUB;
            end

            S_ADDSUB: begin
                if (a_q[31] == b_q[31]) begin
                    sum_d  = {1'b0, ma_q} + {1'b0, mb_q};
                    sign_d = a_q[31];
                end else if (ma_q >= mb_q) begin
                    sum_d  = {1'b0, ma_q - mb_q};
                    sign_d = a_q[31];
                end else begin
                    sum_d  = {1'b0, mb_q - ma_q};
                    sign_d = b_q[31];
                end
                cnt_d   = 5'd0;
                state_d = S_NORM;
            end

            S_NORM: begin
                if (sum_q[24]) begin
                    // Carry out: one right shift; a zero exponent stays zero
                    sum_n  = sum_q >> 1;
                    er_n   = (er_q == 8'd0) ? 8'd0 : er_q + 8'd1;
                    finish = 1'b1;
                end else if (!sum_q[23] && er_q != 8'd0 && cnt_q < LIMIT) begin
                    sum_d = sum_q << 1;
                    er_d  = er_q - 8'd1;
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    finish = 1'b1;
                end
                if (finish) begin
                    sum_d       = sum_n;
                    er_d        = er_n;
                    result_d    = {sign_q, er_n, sum_n[22:0]};
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            er_q        <= '0;
            sum_q       <= '0;
            sign_q      <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            er_q        <= er_d;
            sum_q       <= sum_d;
            sign_q      <= sign_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_fp32_sub_seq.sv
// Bench for fp32_sub_seq: directed cases, backpressure, async reset abort,
// and randomized operands checked against a signed-integer reference model.
module tb_fp32_sub_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    fp32_sub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Operands as signed fixed-point integers aligned to the larger exponent;
    // then a plain signed subtraction and a normalisation loop.
    function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] r, output int lat);
        int    ea, eb, er, n, sgn;
        longint ma, mb, s, mag;
        ea = int'(av[30:23]);
        eb = int'(bv[30:23]);
        ma = longint'({1'b1, av[22:0]});
        mb = longint'({1'b1, bv[22:0]});
        if (ea > eb) begin
            mb = (ea - eb >= 24) ? 0 : mb / (longint'(1) << (ea - eb));
            er = ea;
        end else begin
            ma = (eb - ea >= 24) ? 0 : ma / (longint'(1) << (eb - ea));
            er = eb;
        end
        s = (av[31] ? -ma : ma) - (bv[31] ? -mb : mb);
        if (s < 0)      sgn = 1;
        else if (s > 0) sgn = 0;
        else            sgn = int'(av[31]);
        mag = (s < 0) ? -s : s;
        n = 0;
        if (mag >= (longint'(1) << 24)) begin
            mag = mag / 2;
            if (er != 0) er = (er + 1) % 256;
        end else begin
            while (mag < (longint'(1) << 23) && er != 0 && n < 23) begin
                mag = mag * 2;
                er  = er - 1;
                n   = n + 1;
            end
        end
        r   = {sgn[0], er[7:0], mag[22:0]};
        lat = 4 + n;
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1. Issues one operation, follows it to the result,
    // holds backpressure for 'hold' cycles, then consumes the result.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_r, input int exp_lat, input int hold);
        int          k;
        logic [31:0] e_r;
        int          e_lat;
        exp_q.push_back(exp_r);
        lat_q.push_back(exp_lat);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        k = 1;
        while (!out_valid && k < 40) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            k++;
        end
        e_r   = exp_q.pop_front();
        e_lat = lat_q.pop_front();
        if (!out_valid) begin
            check({tag, "_out_valid_timeout"}, 32'(out_valid), 32'd1);
        end else begin
            check({tag, "_latency"}, 32'(k), 32'(e_lat));
            check({tag, "_result"}, result, e_r);
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'($urandom_range(0, 1));
                a = $urandom;
                b = $urandom;
                @(posedge clk); #1;
                check({tag, "_hold_result"}, result, e_r);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
            check({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
            check({tag, "_release_busy"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic run_rand(input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] r;
        int          lat;
        model(av, bv, r, lat);
        run_op("rand", av, bv, r, lat, $urandom_range(0, 3));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] av, bv;
        int          ea, eb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        check("reset_result", result, 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("sub_3_1",    32'h40400000, 32'h3F800000, 32'h40000000, 4, 0);
        run_op("carry_1_m1", 32'h3F800000, 32'hBF800000, 32'h40000000, 4, 0);
        run_op("neg_1_15",   32'h3F800000, 32'h3FC00000, 32'hBF000000, 5, 1);
        run_op("zero_diff",  32'h3F800000, 32'h3F800000, 32'h34000000, 27, 0);
        run_op("flush_24",   32'h4B800000, 32'h3F800000, 32'h4B800000, 4, 0);
        run_op("backpress",  32'h40400000, 32'h3F800000, 32'h40000000, 4, 10);

        // Async reset in the middle of normalisation
        in_valid = 1'b1;
        a = 32'h3F800000;
        b = 32'h3F800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("mid_norm_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_result", result, 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Randomized: close exponents for cancellation, plus fully random
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    ea = $urandom_range(100, 150);
                    eb = ea + $urandom_range(0, 4) - 2;
                    av = {1'($urandom), 8'(ea), 23'($urandom)};
                    bv = {1'($urandom), 8'(eb), 23'($urandom)};
                end
                1: begin
                    av = $urandom;
                    bv = {1'($urandom), av[30:23], av[22:0] ^ 23'(1 << $urandom_range(0, 22))};
                end
                default: begin
                    av = $urandom;
                    bv = $urandom;
                end
            endcase
            run_rand(av, bv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run can never hang
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "time limit reached");
    end

endmodule
